// File: rtl/pdm_tx_if.sv
// Sample handshake between a sample producer and the PDM transmitter.
interface pdm_tx_if #(
  parameter int unsigned DATA_W = 12
) ();
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/pdm_tx.sv
// First-order delta-sigma PDM transmitter fed by a 2-entry sample FIFO.
// Bit period and samples-per-word are runtime programmable.
module pdm_tx #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned OSR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic [OSR_W-1:0] osr,
  pdm_tx_if.slave          s,
  output logic             pdm_out,
  output logic             underrun,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [OSR_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic              pdm_q, pdm_d;
  logic              underrun_q, underrun_d;
  logic              busy_q, busy_d;

  logic              fifo_empty, fifo_full, push, pop, tick, boundary;
  logic [DATA_W:0]   sum;

  assign fifo_empty = (cnt_q == 2'd0);
  assign fifo_full  = (cnt_q == 2'd2);
  assign s.s_ready  = ~fifo_full;
  assign push       = s.s_valid & ~fifo_full;

  // div/osr are only looked at here, so a mid-run change lands at the next compare.
  assign tick     = (state_q == StRun) && (bit_cnt_q == div);
  assign boundary = tick && (samp_cnt_q == osr);
  assign sum      = {1'b0, acc_q} + {1'b0, cur_q};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cur_d      = cur_q;
    bit_cnt_d  = bit_cnt_q;
    samp_cnt_d = samp_cnt_q;
    pdm_d      = pdm_q;
    underrun_d = 1'b0;
    pop        = 1'b0;

    if (!enable) begin
      state_d    = StIdle;
      acc_d      = '0;
      bit_cnt_d  = '0;
      samp_cnt_d = '0;
      pdm_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          acc_d      = '0;
          bit_cnt_d  = '0;
          samp_cnt_d = '0;
          pdm_d      = 1'b0;
          state_d    = StPrime;
        end
        StPrime: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            cur_d      = mem_q[rd_ptr_q];
            bit_cnt_d  = '0;
            samp_cnt_d = '0;
            state_d    = StRun;
          end
        end
        StRun: begin
          bit_cnt_d = tick ? '0 : bit_cnt_q + 1'b1;
          if (tick) begin
            // acc is never cleared at a boundary so the noise shaping stays continuous.
            acc_d      = sum[DATA_W-1:0];
            pdm_d      = sum[DATA_W];
            samp_cnt_d = (samp_cnt_q == osr) ? '0 : samp_cnt_q + 1'b1;
          end
          if (boundary) begin
            if (!fifo_empty) begin
              pop   = 1'b1;
              cur_d = mem_q[rd_ptr_q];
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s.s_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      acc_q      <= '0;
      cur_q      <= '0;
      bit_cnt_q  <= '0;
      samp_cnt_q <= '0;
      pdm_q      <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      pdm_q      <= pdm_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
    end
  end

  assign pdm_out  = pdm_q;
  assign underrun = underrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Directed bench for pdm_tx: reset, modulation patterns, divider spacing, FIFO flow, enable/reset.
module tb_pdm_tx;
  localparam int unsigned DW = 12;
  localparam int unsigned VW = 8;
  localparam int unsigned OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [VW-1:0] div;
  logic [OW-1:0] osr;
  logic          pdm_out, underrun, busy;
  int            total = 0;
  int            bad = 0;

  pdm_tx_if #(.DATA_W(DW)) bus ();

  pdm_tx #(.DATA_W(DW), .DIV_W(VW), .OSR_W(OW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .div     (div),
    .osr     (osr),
    .s       (bus),
    .pdm_out (pdm_out),
    .underrun(underrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge with s_ready high; the sample is taken on the next posedge.
  task automatic push_one(input logic [DW-1:0] d);
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; div = '0; osr = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (2) @(negedge clk);
    total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL rst_pdm: got %b want 0", pdm_out); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.s_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_idle_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_half;
    logic e;
    div = 8'd0; osr = 8'd255;
    push_one(12'h800);
    enable = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL half_busy: got %b want 1", busy); end
    total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL half_prime_pdm: got %b want 0", pdm_out); end
    @(negedge clk);
    for (int k = 1; k <= 257; k++) begin
      @(negedge clk);
      e = (k % 2 == 0);
      total++;
      if (pdm_out !== e) begin
        bad++; $display("FAIL half_pdm tick %0d: got %b want %b", k, pdm_out, e);
      end
      e = (k == 256);
      total++;
      if (underrun !== e) begin
        bad++; $display("FAIL half_underrun tick %0d: got %b want %b", k, underrun, e);
      end
    end
    enable = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL half_off_busy: got %b want 0", busy); end
  endtask

  task automatic test_density;
    int ones;
    div = 8'd0; osr = 8'd255;
    push_one(12'h000);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    total++; if (ones != 0) begin bad++; $display("FAIL dens_zero: got %0d ones want 0", ones); end
    enable = 1'b0;
    @(negedge clk);
    push_one(12'hFFF);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    ones = 0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      ones += int'(pdm_out);
    end
    total++; if (ones != 4095) begin bad++; $display("FAIL dens_full: got %0d ones want 4095", ones); end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div3;
    logic e;
    div = 8'd3; osr = 8'd255;
    push_one(12'h800);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    // c counts clks since entering RUN; ticks fall on every 4th one.
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      e = (c >= 4) && ((c / 4) % 2 == 0);
      total++;
      if (pdm_out !== e) begin
        bad++; $display("FAIL div3_pdm clk %0d: got %b want %b", c, pdm_out, e);
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [5:0] pat;
    logic       e;
    pat = 6'b001010;
    div = 8'd0; osr = 8'd1;
    bus.s_valid = 1'b1; bus.s_data = 12'h800;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", bus.s_ready); end
    @(negedge clk);
    bus.s_data = 12'hFFF;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1: got %b want 1", bus.s_ready); end
    @(negedge clk);
    bus.s_data = 12'h000;
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: got %b want 0", bus.s_ready); end
    @(negedge clk);
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall: got %b want 0", bus.s_ready); end
    enable = 1'b1;
    @(negedge clk);
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL b2b_prime_ready: got %b want 0", bus.s_ready); end
    @(negedge clk);
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL b2b_pop_ready: got %b want 1", bus.s_ready); end
    @(negedge clk);
    bus.s_valid = 1'b0;
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL b2b_refill: got %b want 0", bus.s_ready); end
    total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL b2b_pdm tick 1: got %b want 0", pdm_out); end
    for (int t = 2; t <= 6; t++) begin
      @(negedge clk);
      e = pat[t-1];
      total++;
      if (pdm_out !== e) begin
        bad++; $display("FAIL b2b_pdm tick %0d: got %b want %b", t, pdm_out, e);
      end
      e = (t == 6);
      total++;
      if (underrun !== e) begin
        bad++; $display("FAIL b2b_underrun tick %0d: got %b want %b", t, underrun, e);
      end
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_drop;
    div = 8'd0; osr = 8'd255;
    push_one(12'hFFF);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    total++; if (pdm_out !== 1'b1) begin bad++; $display("FAIL drop_pre_pdm: got %b want 1", pdm_out); end
    bus.s_valid = 1'b1; bus.s_data = 12'h123;
    @(negedge clk);
    bus.s_valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL drop_pdm: got %b want 0", pdm_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %b want 0", busy); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL drop_ready: got %b want 1", bus.s_ready); end
    push_one(12'h456);
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL drop_kept: got %b want 0", bus.s_ready); end
  endtask

  task automatic test_async_reset;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    push_one(12'h789);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ares_pre_busy: got %b want 1", busy); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL ares_pre_ready: got %b want 0", bus.s_ready); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ares_busy: got %b want 0", busy); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL ares_ready: got %b want 1", bus.s_ready); end
    total++; if (pdm_out !== 1'b0) begin bad++; $display("FAIL ares_pdm: got %b want 0", pdm_out); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ares_underrun: got %b want 0", underrun); end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_one(12'h111);
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL ares_empty1: got %b want 1", bus.s_ready); end
    push_one(12'h222);
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL ares_empty2: got %b want 0", bus.s_ready); end
  endtask

  initial begin
    test_reset();
    test_half();
    test_density();
    test_div3();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdm_tx.md
PDM_TX -- requirements
Module: pdm_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width, unsigned, full scale 2^DATA_W.
REQ-002 SHALL have parameter DIV_W, default 8, width of the bit-period divider input.
REQ-003 SHALL have parameter OSR_W, default 8, width of the bits-per-sample input.
REQ-004 SHALL have port clk  input  1  sole clock (internal HF oscillator domain), all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable  input  1  run request; low forces IDLE.
REQ-007 SHALL have port div  input  DIV_W  bit period minus 1, in clk cycles.
REQ-008 SHALL have port osr  input  OSR_W  PDM bits per sample minus 1.
REQ-009 SHALL have port s_data  input  DATA_W  sample word.
REQ-010 SHALL have port s_valid  input  1  sample offered.
REQ-011 SHALL have port s_ready  output  1  sample accepted when s_valid and s_ready are both high on a posedge.
REQ-012 SHALL have port pdm_out  output  1  registered 1-bit delta-sigma stream for the LVDS/RC feedback pin.
REQ-013 SHALL have port underrun  output  1  one-clk pulse when a sample boundary finds the FIFO empty.
REQ-014 SHALL have port busy  output  1  high in PRIME and RUN.

Function
REQ-015 SHALL buffer samples in a 2-entry FIFO; s_ready = FIFO not full, independent of enable and state.
REQ-016 SHALL, when push and pop coincide on a full FIFO, accept no push (s_ready low); on a non-full FIFO, push and pop in the same cycle SHALL both take effect.
REQ-017 SHALL keep a bit counter 0..div, active only in RUN; tick = (counter == div), counter wraps to 0 on tick; div=0 gives a tick every clk.
REQ-018 SHALL keep a sample counter 0..osr, advancing on tick; a boundary occurs on a tick with counter == osr, and the counter wraps to 0.
REQ-019 SHALL run a first-order modulator on each tick: {c, acc} = acc + cur (DATA_W+1 bit sum); acc takes the low DATA_W bits; pdm_out <= c in the same edge.
REQ-020 SHALL hold pdm_out and acc constant between ticks.
REQ-021 SHALL define states IDLE, PRIME, RUN:
- IDLE: pdm_out=0, acc=0, counters=0; enable -> PRIME.
- PRIME: wait for FIFO non-empty; on non-empty, pop into cur and go to RUN; counters start at 0.
- RUN: modulate per REQ-019; at a boundary, pop the next sample into cur, effective from the next tick; if the FIFO is empty, keep cur and pulse underrun for one clk.
- enable low in any state -> IDLE on the next posedge; FIFO contents are kept.
REQ-022 SHALL not reset acc at sample boundaries (noise-shaping continuity).
REQ-023 SHALL sample div and osr only at tick/boundary compares; changing them mid-run SHALL take effect at the next compare, with no glitch beyond a wrap.
REQ-024 SHALL make the density of ones over 2^DATA_W ticks exactly cur/2^DATA_W for a constant cur.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force: state IDLE, FIFO empty, s_ready=1 after release, pdm_out=0, underrun=0, busy=0, acc=0, cur=0, and both counters 0.
REQ-026 SHALL resume from IDLE on the first posedge after rst_n deasserts; reset mid-RUN SHALL discard buffered samples.

Verification
REQ-027 SHALL cover: DATA_W=12, div=0, osr=255, one sample 0x800 -> pdm_out 0,1,0,1,... from the first RUN tick, then an underrun pulse after 256 ticks.
REQ-028 SHALL cover: sample 0x000 -> pdm_out constant 0; sample 0xFFF -> exactly 4095 ones in 4096 ticks.
REQ-029 SHALL cover: div=3 -> pdm_out changes only every 4th clk, and the tick spacing is exactly 4 clks.
REQ-030 SHALL cover: push 3 samples back-to-back while in IDLE -> the first 2 are accepted and s_ready drops on the 3rd until a pop occurs.
REQ-031 SHALL cover: enable dropped mid-RUN -> next clk pdm_out=0, busy=0, and FIFO count is unchanged.
REQ-032 SHALL cover: rst_n pulsed low mid-RUN, asynchronous to clk -> outputs reach reset values without waiting for an edge, and the FIFO is empty.
